// File: rtl/unidade_controle_pkg.sv
// Shared constants for the multi-cycle control unit: opcodes, time steps, ALU codes.
package unidade_controle_pkg;

    localparam int IR_W   = 10;
    localparam int DATA_W = 16;

    // Instruction opcodes (IR[3:0])
    localparam logic [3:0] OP_MV  = 4'b0000;
    localparam logic [3:0] OP_MVI = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0100;

    // ALU operation codes presented on alu_op
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;

    // Time steps; all four encodings are legal states
    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } estado_t;

    // Map an ALU-class opcode onto the ALU operation code
    function automatic logic [1:0] alu_sel(input logic [3:0] op);
        case (op)
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/unidade_controle_decodifica_reg.sv
// 3->8 register decoder with enable: one-hot select of R0..R7.
module decodificaReg (
    input  logic [2:0] w,
    input  logic       en,
    output logic [7:0] y
);

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_dec
            assign y[gi] = en && (w == 3'(gi));
        end
    endgenerate

endmodule

// File: rtl/unidade_controle.sv
// Multi-cycle control unit: captures an instruction into IR in T0 and sequences
// bus select, register/A/G write enables and the ALU op through T1..T3.
module unidade_controle
    import unidade_controle_pkg::*;
#(
    parameter int IR_W_P   = IR_W,
    parameter int DATA_W_P = DATA_W
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                Run,
    input  logic [DATA_W_P-1:0] DataIn,
    output logic [7:0]          Rout,
    output logic                Gout,
    output logic                Din,
    output logic [7:0]          Rin,
    output logic                Ain,
    output logic                Gin,
    output logic [1:0]          alu_op,
    output logic                IRin,
    output logic                Done,
    output logic [1:0]          estado
);

    estado_t             state_q, state_d;
    logic [IR_W_P-1:0]   ir_q, ir_d;
    logic [7:0]          x_dec, y_dec;
    logic [3:0]          opcode;

    // Only the low IR_W bits of DataIn form an instruction; the rest are don't-care here.
    logic unused_datain;
    assign unused_datain = ^DataIn[DATA_W_P-1:IR_W_P];

    assign opcode = ir_q[3:0];
    assign estado = state_q;

    decodificaReg u_dec_x (
        .w  (ir_q[6:4]),
        .en (1'b1),
        .y  (x_dec)
    );

    decodificaReg u_dec_y (
        .w  (ir_q[9:7]),
        .en (1'b1),
        .y  (y_dec)
    );

    // Next state, IR capture and all control outputs from (state, IR, Run)
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        Rout    = '0;
        Gout    = 1'b0;
        Din     = 1'b0;
        Rin     = '0;
        Ain     = 1'b0;
        Gin     = 1'b0;
        alu_op  = ALU_ADD;
        IRin    = 1'b0;
        Done    = 1'b0;
        case (state_q)
            T0: begin
                IRin = Run;
                if (Run) begin
                    ir_d    = DataIn[IR_W_P-1:0];
                    state_d = T1;
                end
            end
            T1: begin
                case (opcode)
                    OP_MV: begin
                        Rout    = y_dec;
                        Rin     = x_dec;
                        Done    = 1'b1;
                        state_d = T0;
                    end
                    OP_MVI: begin
                        Din     = 1'b1;
                        Rin     = x_dec;
                        Done    = 1'b1;
                        state_d = T0;
                    end
                    OP_ADD, OP_SUB, OP_AND: begin
                        Rout    = x_dec;
                        Ain     = 1'b1;
                        state_d = T2;
                    end
                    default: begin
                        // Unknown opcode: retire as a no-op
                        Done    = 1'b1;
                        state_d = T0;
                    end
                endcase
            end
            T2: begin
                // Only ALU-class instructions reach T2
                Rout    = y_dec;
                Gin     = 1'b1;
                alu_op  = alu_sel(opcode);
                state_d = T3;
            end
            T3: begin
                Gout    = 1'b1;
                Rin     = x_dec;
                Done    = 1'b1;
                state_d = T0;
            end
        endcase
    end

    // State and instruction registers; reset abandons any instruction in flight
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= T0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

endmodule
